// File: rtl/int_issue_select.sv
// Integer issue select: picks one ready queue entry per cycle into a registered valid/ready slot.
// Optional INT_ISSUE_OLDEST_FIRST_EN selects the oldest ready entry by active-list age instead of the lowest index.
package mips_core_pkg;
    typedef enum logic [3:0] {
        ALUCTL_NOP,
        ALUCTL_ADD,
        ALUCTL_SUB,
        ALUCTL_AND,
        ALUCTL_OR,
        ALUCTL_XOR,
        ALUCTL_SLT,
        ALUCTL_SLL,
        ALUCTL_SRL,
        ALUCTL_SRA,
        ALUCTL_LUI
    } AluCtl;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;
endpackage

module int_issue_select #(
    parameter int INT_QUEUE_SIZE = 8,
    parameter int PHYS_REG_IDX   = 6,
    parameter int AL_IDX         = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [INT_QUEUE_SIZE-1:0]              entry_busy,
    input  logic [INT_QUEUE_SIZE-1:0]              rdy_src1,
    input  logic [INT_QUEUE_SIZE-1:0]              rdy_src2,
    input  logic [INT_QUEUE_SIZE*PHYS_REG_IDX-1:0] src1,
    input  logic [INT_QUEUE_SIZE*PHYS_REG_IDX-1:0] src2,
    input  logic [INT_QUEUE_SIZE*DATA_WIDTH-1:0]   imm,
    input  mips_core_pkg::AluCtl                   alu_ctl [INT_QUEUE_SIZE],
    input  logic [INT_QUEUE_SIZE-1:0]              is_branch,
    input  mips_core_pkg::BranchOutcome            prediction [INT_QUEUE_SIZE],
    input  logic [INT_QUEUE_SIZE*ADDR_WIDTH-1:0]   recovery_target,
    input  logic [INT_QUEUE_SIZE*AL_IDX-1:0]       al_id,
    input  logic [AL_IDX-1:0]                      al_head,
    input  logic                                   flush_valid,
    input  logic [AL_IDX-1:0]                      flush_id,
    input  logic                                   ex_ready,
    output logic [INT_QUEUE_SIZE-1:0]              grant,
    output logic                                   out_valid,
    output logic [PHYS_REG_IDX-1:0]                out_src1,
    output logic [PHYS_REG_IDX-1:0]                out_src2,
    output logic [DATA_WIDTH-1:0]                  out_imm,
    output mips_core_pkg::AluCtl                   out_alu_ctl,
    output logic                                   out_is_branch,
    output mips_core_pkg::BranchOutcome            out_prediction,
    output logic [ADDR_WIDTH-1:0]                  out_recovery_target,
    output logic [AL_IDX-1:0]                      out_al_id
);
    import mips_core_pkg::*;

    localparam int IDX_W = (INT_QUEUE_SIZE > 1) ? $clog2(INT_QUEUE_SIZE) : 1;

    logic [PHYS_REG_IDX-1:0] src1_arr [INT_QUEUE_SIZE];
    logic [PHYS_REG_IDX-1:0] src2_arr [INT_QUEUE_SIZE];
    logic [DATA_WIDTH-1:0]   imm_arr  [INT_QUEUE_SIZE];
    logic [ADDR_WIDTH-1:0]   tgt_arr  [INT_QUEUE_SIZE];
    logic [AL_IDX-1:0]       id_arr   [INT_QUEUE_SIZE];

    for (genvar g = 0; g < INT_QUEUE_SIZE; g++) begin : g_unpack
        assign src1_arr[g] = src1[g*PHYS_REG_IDX +: PHYS_REG_IDX];
        assign src2_arr[g] = src2[g*PHYS_REG_IDX +: PHYS_REG_IDX];
        assign imm_arr[g]  = imm[g*DATA_WIDTH +: DATA_WIDTH];
        assign tgt_arr[g]  = recovery_target[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign id_arr[g]   = al_id[g*AL_IDX +: AL_IDX];
    end

    logic [INT_QUEUE_SIZE-1:0] candidate;
    logic                      slot_free;
    logic                      sel_found;
    logic [IDX_W-1:0]          sel_idx;
    logic                      do_issue;

    assign candidate = entry_busy & rdy_src1 & rdy_src2;
    assign slot_free = !out_valid || ex_ready;

`ifdef INT_ISSUE_OLDEST_FIRST_EN
    localparam int LVLS = $clog2(INT_QUEUE_SIZE);

    // Pairwise min-age tree; ids are unique so strict compare never ties between valid nodes.
    logic              lvl_vld [LVLS+1][INT_QUEUE_SIZE];
    logic [IDX_W-1:0]  lvl_idx [LVLS+1][INT_QUEUE_SIZE];
    logic [AL_IDX-1:0] lvl_age [LVLS+1][INT_QUEUE_SIZE];

    always_comb begin
        for (int l = 0; l <= LVLS; l++) begin
            for (int i = 0; i < INT_QUEUE_SIZE; i++) begin
                lvl_vld[l][i] = 1'b0;
                lvl_idx[l][i] = '0;
                lvl_age[l][i] = '0;
            end
        end
        for (int i = 0; i < INT_QUEUE_SIZE; i++) begin
            lvl_vld[0][i] = candidate[i];
            lvl_idx[0][i] = IDX_W'(i);
            lvl_age[0][i] = id_arr[i] - al_head;
        end
        for (int l = 1; l <= LVLS; l++) begin
            for (int i = 0; i < (INT_QUEUE_SIZE >> l); i++) begin
                if (lvl_vld[l-1][2*i+1] &&
                    (!lvl_vld[l-1][2*i] || (lvl_age[l-1][2*i+1] < lvl_age[l-1][2*i]))) begin
                    lvl_vld[l][i] = 1'b1;
                    lvl_idx[l][i] = lvl_idx[l-1][2*i+1];
                    lvl_age[l][i] = lvl_age[l-1][2*i+1];
                end else begin
                    lvl_vld[l][i] = lvl_vld[l-1][2*i];
                    lvl_idx[l][i] = lvl_idx[l-1][2*i];
                    lvl_age[l][i] = lvl_age[l-1][2*i];
                end
            end
        end
        sel_found = lvl_vld[LVLS][0];
        sel_idx   = lvl_idx[LVLS][0];
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = INT_QUEUE_SIZE - 1; i >= 0; i--) begin
            if (candidate[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    assign do_issue = rst_n && !flush_valid && slot_free && sel_found;

    always_comb begin
        grant = '0;
        if (do_issue) begin
            grant[sel_idx] = 1'b1;
        end
    end

    logic [AL_IDX-1:0] slot_age;
    logic [AL_IDX-1:0] flush_age;

    // Modular subtraction keeps ages correct across active-list wrap.
    assign slot_age  = out_al_id - al_head;
    assign flush_age = flush_id - al_head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid           <= 1'b0;
            out_src1            <= '0;
            out_src2            <= '0;
            out_imm             <= '0;
            out_alu_ctl         <= ALUCTL_NOP;
            out_is_branch       <= 1'b0;
            out_prediction      <= TAKEN;
            out_recovery_target <= '0;
            out_al_id           <= '0;
        end else if (flush_valid) begin
            if ((slot_age > flush_age) || ex_ready) begin
                out_valid <= 1'b0;
            end
        end else if (do_issue) begin
            out_valid           <= 1'b1;
            out_src1            <= src1_arr[sel_idx];
            out_src2            <= src2_arr[sel_idx];
            out_imm             <= imm_arr[sel_idx];
            out_alu_ctl         <= alu_ctl[sel_idx];
            out_is_branch       <= is_branch[sel_idx];
            out_prediction      <= prediction[sel_idx];
            out_recovery_target <= tgt_arr[sel_idx];
            out_al_id           <= id_arr[sel_idx];
        end else if (ex_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_int_issue_select.sv
// Directed bench for int_issue_select; expected grant value in the age test depends on INT_ISSUE_OLDEST_FIRST_EN.
module tb_int_issue_select;
    import mips_core_pkg::*;

    localparam int N  = 8;
    localparam int PR = 6;
    localparam int AL = 5;
    localparam int DW = 32;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      entry_busy, rdy_src1, rdy_src2, is_branch;
    logic [N*PR-1:0]   src1, src2;
    logic [N*DW-1:0]   imm;
    AluCtl             alu_ctl [N];
    BranchOutcome      prediction [N];
    logic [N*AW-1:0]   recovery_target;
    logic [N*AL-1:0]   al_id;
    logic [AL-1:0]     al_head, flush_id, out_al_id;
    logic              flush_valid, ex_ready, out_valid, out_is_branch;
    logic [N-1:0]      grant;
    logic [PR-1:0]     out_src1, out_src2;
    logic [DW-1:0]     out_imm;
    AluCtl             out_alu_ctl;
    BranchOutcome      out_prediction;
    logic [AW-1:0]     out_recovery_target;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    int_issue_select dut (
        .clk(clk), .rst_n(rst_n), .entry_busy(entry_busy), .rdy_src1(rdy_src1),
        .rdy_src2(rdy_src2), .src1(src1), .src2(src2), .imm(imm), .alu_ctl(alu_ctl),
        .is_branch(is_branch), .prediction(prediction), .recovery_target(recovery_target),
        .al_id(al_id), .al_head(al_head), .flush_valid(flush_valid), .flush_id(flush_id),
        .ex_ready(ex_ready), .grant(grant), .out_valid(out_valid), .out_src1(out_src1),
        .out_src2(out_src2), .out_imm(out_imm), .out_alu_ctl(out_alu_ctl),
        .out_is_branch(out_is_branch), .out_prediction(out_prediction),
        .out_recovery_target(out_recovery_target), .out_al_id(out_al_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic default_ids();
        for (int i = 0; i < N; i++) al_id[i*AL +: AL] = AL'(i);
    endtask

    initial begin
        AluCtl ops [N];
        logic [N-1:0] exp_age_grant;
        ops = '{ALUCTL_ADD, ALUCTL_SUB, ALUCTL_AND, ALUCTL_OR,
                ALUCTL_XOR, ALUCTL_SLT, ALUCTL_SLL, ALUCTL_SRL};
        for (int i = 0; i < N; i++) begin
            src1[i*PR +: PR]            = PR'(10 + i);
            src2[i*PR +: PR]            = PR'(20 + i);
            imm[i*DW +: DW]             = 32'hA000_0000 + 32'(i);
            recovery_target[i*AW +: AW] = 32'h0000_1000 + 32'(4 * i);
            alu_ctl[i]                  = ops[i];
            prediction[i]               = (i % 2 == 1) ? TAKEN : NOT_TAKEN;
        end
        is_branch   = 8'b1010_0100;
        default_ids();
        rst_n       = 1'b0;
        entry_busy  = 8'b0010_0100;
        rdy_src1    = '1;
        rdy_src2    = '1;
        al_head     = '0;
        flush_valid = 1'b0;
        flush_id    = '0;
        ex_ready    = 1'b1;

        // Reset with candidates present
        sample();
        chk("rst_grant", grant, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_src1", out_src1, 6'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_alu", out_alu_ctl, ALUCTL_NOP);
        chk("rst_pred", out_prediction, TAKEN);
        next_cycle();
        rst_n = 1'b1;
        sample();
        chk("post_rst_grant", grant, 8'b0000_0100);
        next_cycle();
        entry_busy = 8'b0010_0000;
        sample();
        chk("e2_valid", out_valid, 1'b1);
        chk("e2_src1", out_src1, 6'd12);
        chk("e2_pred", out_prediction, NOT_TAKEN);
        chk("e2_branch", out_is_branch, 1'b1);
        chk("b2b_grant", grant, 8'b0010_0000);

        // Single issue of entry 3, then drain
        next_cycle();
        chk("e5_src2", out_src2, 6'd25);
        entry_busy = 8'b0000_1000;
        sample();
        chk("e3_grant", grant, 8'b0000_1000);
        next_cycle();
        entry_busy = '0;
        sample();
        chk("e3_valid", out_valid, 1'b1);
        chk("e3_src1", out_src1, 6'd13);
        chk("e3_imm", out_imm, 32'hA000_0003);
        chk("e3_alu", out_alu_ctl, ALUCTL_OR);
        chk("e3_tgt", out_recovery_target, 32'h0000_100C);
        chk("empty_grant", grant, 8'h00);
        next_cycle();
        sample();
        chk("drain_valid", out_valid, 1'b0);

        // Stall: entry 4 in slot, entry 1 waiting
        entry_busy = 8'b0001_0000;
        next_cycle();
        ex_ready   = 1'b0;
        entry_busy = 8'b0000_0010;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("stall_grant", grant, 8'h00);
            chk("stall_src1", out_src1, 6'd14);
            chk("stall_valid", out_valid, 1'b1);
            next_cycle();
        end
        ex_ready = 1'b1;
        sample();
        chk("unstall_grant", grant, 8'b0000_0010);
        next_cycle();
        entry_busy = '0;
        sample();
        chk("unstall_src1", out_src1, 6'd11);
        next_cycle();

        // Flush across wrap: slot id 1 is younger than flush id 31 with head 30
        al_head                = 5'd30;
        al_id[5*AL +: AL]      = 5'd1;
        entry_busy             = 8'b0010_0000;
        next_cycle();
        ex_ready    = 1'b0;
        entry_busy  = 8'b0000_0001;
        flush_valid = 1'b1;
        flush_id    = 5'd31;
        sample();
        chk("flush_young_slot_id", out_al_id, 5'd1);
        chk("flush_grant", grant, 8'h00);
        next_cycle();
        sample();
        chk("flush_squash", out_valid, 1'b0);

        // Same flush with slot id 30 (oldest) is kept
        flush_valid       = 1'b0;
        ex_ready          = 1'b1;
        al_id[5*AL +: AL] = 5'd30;
        entry_busy        = 8'b0010_0000;
        next_cycle();
        ex_ready    = 1'b0;
        entry_busy  = 8'b0000_0001;
        flush_valid = 1'b1;
        sample();
        chk("flush2_grant", grant, 8'h00);
        next_cycle();
        sample();
        chk("flush_keep", out_valid, 1'b1);
        chk("flush_keep_id", out_al_id, 5'd30);
        ex_ready = 1'b1;
        next_cycle();
        sample();
        chk("flush_consume", out_valid, 1'b0);
        flush_valid = 1'b0;
        entry_busy  = '0;
        next_cycle();

        // Operand readiness gates candidacy
        al_head    = '0;
        default_ids();
        entry_busy = 8'b0100_0001;
        rdy_src2   = 8'b1111_1110;
        sample();
        chk("nrdy_grant", grant, 8'b0100_0000);
        next_cycle();
        entry_busy = 8'b0000_0001;
        rdy_src2   = '1;
        sample();
        chk("e6_src1", out_src1, 6'd16);
        chk("rdy_grant", grant, 8'b0000_0001);
        next_cycle();
        entry_busy = '0;
        sample();
        chk("e0_src1", out_src1, 6'd10);
        next_cycle();

        // Age-ordered vs index-ordered selection
        al_head           = 5'd10;
        al_id[0*AL +: AL] = 5'd12;
        al_id[7*AL +: AL] = 5'd11;
        entry_busy        = 8'b1000_0001;
`ifdef INT_ISSUE_OLDEST_FIRST_EN
        exp_age_grant = 8'b1000_0000;
`else
        exp_age_grant = 8'b0000_0001;
`endif
        sample();
        chk("age_grant", grant, exp_age_grant);
        next_cycle();
        entry_busy = '0;
        sample();
        chk("age_slot_id", out_al_id, exp_age_grant[7] ? 5'd11 : 5'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
